// File: rtl/breath_pkg.sv
// -----------------------------------------------------------------------------
// breath_pkg
//   Shared definitions for the breathing-LED duty generator.
//   - breath_state_e : ramp FSM states (rise, hold at peak, fall, hold at floor)
//   - hold_width()   : width of the peak-hold tick counter for a given hold length
//   - is_rising()    : true for the states that report dir=1
// -----------------------------------------------------------------------------
package breath_pkg;

    typedef enum logic [1:0] {
        StRise   = 2'd0,
        StHoldHi = 2'd1,
        StFall   = 2'd2,
        StHoldLo = 2'd3
    } breath_state_e;

    // A single hold step still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned hold_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic logic is_rising(input breath_state_e st);
        return (st == StRise) || (st == StHoldHi);
    endfunction

endpackage

// File: rtl/gamma_sq.sv
// -----------------------------------------------------------------------------
// gamma_sq
//   Squares the brightness level to give a perceptually even ramp, scales the
//   square down to the duty width and registers it (one cycle from i_lvl).
//   Ports:
//     clk50     in   clock, rising edge
//     rst       in   asynchronous active-high reset, clears the staging register
//     i_lvl     in   lvlBits brightness level
//     o_staged  out  dutyBits registered (lvl*lvl) >> (2*lvlBits-dutyBits)
// -----------------------------------------------------------------------------
module gamma_sq #(
    parameter int unsigned lvlBits  = 10,
    parameter int unsigned dutyBits = 19
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic [lvlBits-1:0]  i_lvl,
    output logic [dutyBits-1:0] o_staged
);

    localparam int unsigned SqW   = 2 * lvlBits;
    localparam int unsigned Shift = SqW - dutyBits;

    logic [SqW-1:0]      w_sq;
    logic [dutyBits-1:0] w_scaled;
    logic [dutyBits-1:0] r_staged;

    assign w_sq     = SqW'(i_lvl) * SqW'(i_lvl);
    // Top dutyBits of the square are exactly the right-shifted value.
    assign w_scaled = w_sq[SqW-1 -: dutyBits];

    // The discarded fraction bits are intentionally dropped.
    if (Shift > 0) begin : g_frac
        logic w_unused_frac;
        assign w_unused_frac = ^w_sq[Shift-1:0];
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_staged <= '0;
        end else begin
            r_staged <= w_scaled;
        end
    end

    assign o_staged = r_staged;

endmodule

// File: rtl/breath_gen.sv
// -----------------------------------------------------------------------------
// breath_gen
//   Breathing-LED duty generator. A prescaler produces a step tick every
//   2**prescBits enabled cycles; each tick moves a triangular level ramp
//   (rise, hold at max, fall, hold at 0). The level is squared by gamma_sq and
//   the result is handed to the PWM only on its period boundary, so a PWM period
//   never sees its duty change mid-way.
//   Ports:
//     clk50       in   sole clock, rising edge
//     rst         in   asynchronous active-high reset
//     en          in   advance enable; low freezes prescaler, level and state
//     period_end  in   one-cycle PWM period-boundary strobe, loads duty
//     duty        out  dutyBits registered duty word
//     duty_upd    out  high for the one cycle in which duty first shows a new value
//     dir         out  1 in rise / peak hold, 0 in fall / floor hold
// -----------------------------------------------------------------------------
module breath_gen
    import breath_pkg::*;
#(
    parameter int unsigned dutyBits  = 19,
    parameter int unsigned lvlBits   = 10,
    parameter int unsigned prescBits = 21,
    parameter int unsigned holdSteps = 4
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic                en,
    input  logic                period_end,
    output logic [dutyBits-1:0] duty,
    output logic                duty_upd,
    output logic                dir
);

    localparam int unsigned        HoldW    = hold_width(holdSteps);
    localparam logic [lvlBits-1:0] LvlOne   = lvlBits'(1);
    localparam logic [lvlBits-1:0] LvlMax   = '1;
    localparam logic [lvlBits-1:0] LvlNear  = LvlMax - LvlOne;
    localparam logic [HoldW-1:0]   HoldLast = HoldW'(holdSteps - 1);

    logic [prescBits-1:0] r_presc;
    logic [lvlBits-1:0]   r_lvl;
    logic [HoldW-1:0]     r_hold;
    breath_state_e        r_state;
    logic [dutyBits-1:0]  r_duty;
    logic                 r_upd;

    logic [lvlBits-1:0]   w_lvl_nxt;
    logic [HoldW-1:0]     w_hold_nxt;
    breath_state_e        w_state_nxt;
    logic                 w_tick;
    logic [dutyBits-1:0]  w_staged;

    // -------------------------------------------------------------------------
    // Step prescaler
    // -------------------------------------------------------------------------
    assign w_tick = en && (&r_presc);

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= r_presc + prescBits'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Ramp FSM: level and hold counter only move on a step tick
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_lvl_nxt   = r_lvl;
        w_hold_nxt  = r_hold;
        if (w_tick) begin
            unique case (r_state)
                StRise: begin
                    // Saturate at max; enter the hold on the tick that reaches it.
                    if (r_lvl != LvlMax) begin
                        w_lvl_nxt = r_lvl + LvlOne;
                    end
                    if (r_lvl >= LvlNear) begin
                        w_state_nxt = StHoldHi;
                        w_hold_nxt  = '0;
                    end
                end
                StHoldHi: begin
                    if (r_hold == HoldLast) begin
                        w_state_nxt = StFall;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + HoldW'(1);
                    end
                end
                StFall: begin
                    // Saturate at 0; enter the floor hold on the tick that reaches it.
                    if (r_lvl != '0) begin
                        w_lvl_nxt = r_lvl - LvlOne;
                    end
                    if (r_lvl <= LvlOne) begin
                        w_state_nxt = StHoldLo;
                        w_hold_nxt  = '0;
                    end
                end
                StHoldLo: begin
                    if (r_hold == HoldLast) begin
                        w_state_nxt = StRise;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + HoldW'(1);
                    end
                end
                default: begin
                    w_state_nxt = StRise;
                end
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_state <= StRise;
            r_lvl   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lvl   <= w_lvl_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Gamma stage
    // -------------------------------------------------------------------------
    gamma_sq #(
        .lvlBits  (lvlBits),
        .dutyBits (dutyBits)
    ) u_gamma_sq (
        .clk50    (clk50),
        .rst      (rst),
        .i_lvl    (r_lvl),
        .o_staged (w_staged)
    );

    // -------------------------------------------------------------------------
    // Duty handoff: only at the PWM period boundary. The staged value sampled
    // here predates any tick on the same edge, so that tick shows up one PWM
    // period later. duty_upd is raised together with the new duty value and
    // only when the value actually differs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_duty <= '0;
            r_upd  <= 1'b0;
        end else if (period_end) begin
            r_duty <= w_staged;
            r_upd  <= (w_staged != r_duty);
        end else begin
            r_upd  <= 1'b0;
        end
    end

    assign duty     = r_duty;
    assign duty_upd = r_upd;
    assign dir      = is_rising(r_state);

endmodule

// File: tb/tb_breath_gen.sv
// -----------------------------------------------------------------------------
// tb_breath_gen
//   Directed bench for breath_gen with dutyBits=8, lvlBits=4, prescBits=2,
//   holdSteps=2. Edge k counts rising edges after reset release; with period_end
//   every cycle, lvl=n after edge 4n and duty=n*n after edge 4n+2.
// -----------------------------------------------------------------------------
module tb_breath_gen;

    logic       clk50 = 1'b0;
    logic       rst;
    logic       en;
    logic       period_end;
    logic [7:0] duty;
    logic       duty_upd;
    logic       dir;

    int n_vec = 0;
    int n_err = 0;

    breath_gen #(
        .dutyBits  (8),
        .lvlBits   (4),
        .prescBits (2),
        .holdSteps (2)
    ) dut (
        .clk50      (clk50),
        .rst        (rst),
        .en         (en),
        .period_end (period_end),
        .duty       (duty),
        .duty_upd   (duty_upd),
        .dir        (dir)
    );

    always #5 clk50 = ~clk50;

    task automatic clk_step();
        @(posedge clk50);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        period_end = 1'b0;
        clk_step();
        clk_step();
        rst = 1'b0;
    endtask

    // Expected duty after edge k of a free-running full cycle, period_end every cycle.
    function automatic int exp_full(input int k);
        if (k < 2)    return 0;
        if (k <= 62)  return ((k - 2) / 4) * ((k - 2) / 4);
        if (k <= 73)  return 225;
        if (k <= 130) return (15 - (k - 70) / 4) * (15 - (k - 70) / 4);
        if (k <= 141) return 0;
        return 1;
    endfunction

    task automatic test_reset();
        do_reset();
        en         = 1'b1;
        period_end = 1'b1;
        for (int k = 1; k <= 30; k++) clk_step();
        n_vec++;
        if (duty !== 8'd49) begin
            n_err++;
            $display("FAIL reset_pre duty got %0d expected 49", duty);
        end
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if (duty !== 8'd0 || duty_upd !== 1'b0 || dir !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async duty/upd/dir got %0d/%0d/%0d expected 0/0/1",
                     duty, duty_upd, dir);
        end
        clk_step();
        rst = 1'b0;
    endtask

    task automatic test_full_cycle();
        do_reset();
        en         = 1'b1;
        period_end = 1'b1;
        for (int k = 1; k <= 145; k++) begin
            clk_step();
            n_vec++;
            if (duty !== 8'(exp_full(k))) begin
                n_err++;
                $display("FAIL full_duty k=%0d got %0d expected %0d", k, duty, exp_full(k));
            end
            n_vec++;
            if (dir !== ((k < 68 || k >= 136) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL full_dir k=%0d got %0d", k, dir);
            end
        end
    endtask

    task automatic test_boundary_latch();
        int lat [6] = '{0, 16, 64, 144, 225, 144};
        int exp_d;
        logic exp_u;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            period_end = (k % 16 == 4);
            clk_step();
            exp_d = (k < 4) ? 0 : lat[(k - 4) / 16];
            exp_u = (k == 20 || k == 36 || k == 52 || k == 68 || k == 84);
            n_vec++;
            if (duty !== 8'(exp_d) || duty_upd !== exp_u) begin
                n_err++;
                $display("FAIL latch k=%0d duty/upd got %0d/%0d expected %0d/%0d",
                         k, duty, duty_upd, exp_d, exp_u);
            end
        end
        period_end = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        en         = 1'b1;
        period_end = 1'b1;
        for (int k = 1; k <= 30; k++) clk_step();
        en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            clk_step();
            n_vec++;
            if (duty !== 8'd49 || duty_upd !== 1'b0 || dir !== 1'b1) begin
                n_err++;
                $display("FAIL freeze c=%0d duty/upd/dir got %0d/%0d/%0d expected 49/0/1",
                         k, duty, duty_upd, dir);
            end
        end
        en = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            clk_step();
            n_vec++;
            if (duty !== ((r < 4) ? 8'd49 : 8'd64)) begin
                n_err++;
                $display("FAIL resume r=%0d got %0d expected %0d", r, duty,
                         (r < 4) ? 49 : 64);
            end
        end
    endtask

    task automatic test_reset_mid_fall();
        do_reset();
        en         = 1'b1;
        period_end = 1'b1;
        for (int k = 1; k <= 91; k++) clk_step();
        n_vec++;
        if (duty !== 8'd100 || dir !== 1'b0) begin
            n_err++;
            $display("FAIL midfall_pre duty/dir got %0d/%0d expected 100/0", duty, dir);
        end
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if (duty !== 8'd0 || dir !== 1'b1 || duty_upd !== 1'b0) begin
            n_err++;
            $display("FAIL midfall_rst duty/dir/upd got %0d/%0d/%0d expected 0/1/0",
                     duty, dir, duty_upd);
        end
        clk_step();
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            clk_step();
            if (k % 4 == 2) begin
                n_vec++;
                if (duty !== 8'(((k - 2) / 4) * ((k - 2) / 4)) || dir !== 1'b1) begin
                    n_err++;
                    $display("FAIL midfall_restart k=%0d duty/dir got %0d/%0d expected %0d/1",
                             k, duty, dir, ((k - 2) / 4) * ((k - 2) / 4));
                end
            end
        end
    endtask

    task automatic test_duty_upd();
        logic exp_u;
        do_reset();
        en         = 1'b1;
        period_end = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            clk_step();
            exp_u = (k % 4 == 2) && ((k >= 6 && k <= 62) || k >= 74);
            n_vec++;
            if (duty_upd !== exp_u) begin
                n_err++;
                $display("FAIL duty_upd k=%0d got %0d expected %0d", k, duty_upd, exp_u);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        period_end = 1'b0;
        test_reset();
        test_full_cycle();
        test_boundary_latch();
        test_freeze();
        test_reset_mid_fall();
        test_duty_upd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/breath_gen.md
BREATH_GEN -- requirements
Module: breath_gen

Interface
REQ-001 The block SHALL have parameter dutyBits, default 19: width of the duty word delivered to the downstream PWM.
REQ-002 The block SHALL have parameter lvlBits, default 10: width of the brightness level counter; 2*lvlBits >= dutyBits.
REQ-003 The block SHALL have parameter prescBits, default 21: step prescaler width; one level step every 2**prescBits enabled cycles.
REQ-004 The block SHALL have parameter holdSteps, default 4: number of step ticks spent at each peak; holdSteps >= 1.
REQ-005 The block SHALL have port clk50  in  1  sole clock, all logic on rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port en  in  1  advance enable; low freezes prescaler, level and state.
REQ-008 The block SHALL have port period_end  in  1  one-cycle strobe from the PWM at its period boundary.
REQ-009 The block SHALL have port duty  out  dutyBits  duty word to the PWM, registered.
REQ-010 The block SHALL have port duty_upd  out  1  one-cycle pulse in the cycle after duty took a new, different value.
REQ-011 The block SHALL have port dir  out  1  1 while in RISE or HOLD_HI, 0 otherwise.

Function
REQ-012 A step tick SHALL occur in a cycle where en=1 and the prescaler equals all-ones; the prescaler SHALL increment on every en=1 cycle and wrap to 0.
REQ-013 The FSM SHALL have exactly the states RISE, HOLD_HI, FALL and HOLD_LO, and SHALL change state and level only on a step tick.
REQ-014 In RISE, a tick SHALL increment lvl; when lvl reaches 2**lvlBits-1 on that tick, the FSM SHALL go to HOLD_HI and clear hold_cnt.
REQ-015 In HOLD_HI, a tick SHALL increment hold_cnt; on the tick where hold_cnt==holdSteps-1, the FSM SHALL go to FALL.
REQ-016 In FALL, a tick SHALL decrement lvl; when lvl reaches 0 on that tick, the FSM SHALL go to HOLD_LO and clear hold_cnt.
REQ-017 In HOLD_LO, the FSM SHALL behave as in HOLD_HI and then go to RISE; lvl SHALL never wrap past 0 or past the maximum.
REQ-018 The gamma stage SHALL register staged = (lvl*lvl) >> (2*lvlBits-dutyBits) every cycle, with 1-cycle latency from lvl.
REQ-019 duty SHALL load staged only in a cycle with period_end=1, and SHALL hold its value otherwise, so the PWM never sees a mid-period change.
REQ-020 When a tick and period_end coincide, duty SHALL load the staged value from before that tick; the new level takes effect at the next period_end.
REQ-021 When period_end loads a value equal to the current duty, duty_upd SHALL stay low.
REQ-022 While en=0, period_end SHALL still load staged into duty.

Reset
REQ-023 Asserting rst SHALL immediately set prescaler=0, lvl=0, hold_cnt=0, state=RISE, staged=0, duty=0, duty_upd=0 and dir=1.
REQ-024 When rst is asserted mid-ramp, the block SHALL abandon the ramp and, after release, restart from level 0 in RISE with no residual duty.

Structure
REQ-025 The state enum (RISE, HOLD_HI, FALL, HOLD_LO) SHALL be defined in a shared package, breath_pkg.
REQ-026 The gamma squarer and staging register SHALL be a sub-module, gamma_sq, parameterised by lvlBits and dutyBits.
REQ-027 All other logic SHALL reside in breath_gen.

Verification
REQ-028 The bench SHALL use dutyBits=8, lvlBits=4, prescBits=2, holdSteps=2 for all scenarios below.
REQ-029 Full cycle: en=1 and period_end every cycle -> lvl 0..15 at one step per 4 cycles; duty follows 0,1,4,9,...,225; 2 ticks in HOLD_HI; descent 225..0; 2 ticks in HOLD_LO; then repeat.
REQ-030 Boundary latch: period_end every 16 cycles -> duty changes only in the cycle after a period_end and always equals the square of lvl at that time; a tick on the same cycle as period_end is deferred one period.
REQ-031 Freeze: drop en at lvl=7 in RISE for 40 cycles -> lvl, state and prescaler are unchanged; duty stays 49 across period_end strobes; ramp resumes at lvl 8.
REQ-032 Reset mid-fall: assert rst asynchronously at lvl=10 in FALL, between clock edges -> duty=0 and dir=1 before the next edge; after release, RISE restarts from 0.
REQ-033 duty_upd: during HOLD_HI with period_end each cycle -> duty_upd pulses exactly once on entry to 225, then stays low while duty is held at 225.
